fpalu_arb: RTL and testbench
============================

FPALU_ARB -- requirements
Module: fpalu_arb

Interface
REQ-001 SHALL have parameter ALU_LAT, default 4: FPALU pipeline latency in clk_fast cycles, from operand register to alu_y.
REQ-002 SHALL have parameter LOCK_MAX, default 64: maximum consecutive locked grants.
REQ-003 SHALL have port clk_fast, input, 1 bit: fast clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N presents an operation.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each: operation accepted this cycle.
REQ-007 SHALL have ports req0_op and req1_op, input, 2 bits each: opcode, 10 = MUL, 11 = ADD.
REQ-008 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 29 bits each: FP29i operands.
REQ-009 SHALL have ports req0_lock and req1_lock, input, 1 bit each: request to keep the grant for the next cycle.
REQ-010 SHALL have port flush, input, 1 bit: synchronous abort of in-flight work.
REQ-011 SHALL have port alu_op, output, 2 bits: registered opcode, 00 = NOP.
REQ-012 SHALL have ports alu_a and alu_b, output, 29 bits each: registered operands.
REQ-013 SHALL have port alu_y, input, 29 bits: FPALU result.
REQ-014 SHALL have port alu_clk_en, output, 1 bit: FPALU clock-gate enable.
REQ-015 SHALL have ports rsp0_valid and rsp1_valid, output, 1 bit each: result belongs to requester N.
REQ-016 SHALL have port rsp_y, output, 29 bits: result, equal to alu_y.
REQ-017 SHALL have port busy, output, 1 bit: any operation in flight.

Function
REQ-018 SHALL accept at most one request per cycle; a handshake is reqN_valid & reqN_ready.
REQ-019 SHALL drive reqN_ready combinationally: 1 when N is granted and flush=0.
REQ-020 SHALL arbitrate round-robin with a last-grant pointer: if both requesters are valid, grant the one not last granted; a single valid requester wins.
REQ-021 SHALL keep the grant on requester N, ignoring the other, while reqN_lock=1 with N's handshake, up to LOCK_MAX consecutive grants.
REQ-022 SHALL force release after LOCK_MAX locked grants, give the grant to the other requester for one cycle if it is valid, and then honour a new lock request.
REQ-023 SHALL end a lock when the locked requester drops valid; the grant then returns to round-robin.
REQ-024 SHALL register op, a and b into alu_op/alu_a/alu_b on each handshake; in a cycle without a handshake, alu_op SHALL be 00 and alu_a/alu_b SHALL hold their values.
REQ-025 SHALL track each issue in an (ALU_LAT+1)-deep {valid, id} shift register.
REQ-026 SHALL assert rspN_valid for one cycle exactly ALU_LAT+1 cycles after the handshake cycle; rsp_y = alu_y in that cycle.
REQ-027 SHALL sustain back-to-back issues at one per cycle, with responses returned in issue order and no bubbles.
REQ-028 SHALL drive alu_clk_en = any reqN_valid | any valid in the tag pipeline | alu_op != 00.
REQ-029 SHALL drive busy = any valid in the tag pipeline | alu_op != 00.
REQ-030 SHALL, on flush=1, clear the tag pipeline, set alu_op to 00, clear the lock counter and set the pointer to 1; no rspN_valid SHALL appear for operations issued before the flush.
REQ-031 SHALL give flush priority when flush and reqN_valid occur in the same cycle: no handshake that cycle.
REQ-032 SHALL never assert rsp0_valid and rsp1_valid in the same cycle.

Reset
REQ-033 SHALL, while rst_n=0, force req0_ready, req1_ready, alu_op, alu_a, alu_b, rsp0_valid, rsp1_valid, alu_clk_en and busy to 0, and rsp_y SHALL follow alu_y.
REQ-034 SHALL reset the pointer to 1 (req0 wins the first contention), the lock counter to 0 and the tag pipeline to empty.
REQ-035 SHALL discard in-flight operations on reset mid-operation, with no response after release.

Structure
REQ-036 SHALL take from shared package fpalu_pkg: opcode constants OP_NOP=00, OP_MUL=10, OP_ADD=11; FP29i widths (S=1, E=6, M=22, W=29); FP16 widths.
REQ-037 SHALL place arbitration in sub-module fpalu_arb_rr (2-way round-robin with lock counter and forced release); tag pipeline and operand registers SHALL sit in the top level.

Verification
REQ-038 SHALL cover: req0 only, MUL, a=0x0F000000, b=0x0F000000 at cycle 0 -> alu_op=10 at cycle 1, rsp0_valid at cycle 5, rsp1_valid never.
REQ-039 SHALL cover: both valid continuously for 8 cycles after reset -> grants 0,1,0,1,0,1,0,1; responses alternate in the same order, starting at cycle 5.
REQ-040 SHALL cover: req1_lock held, both valid for 70 cycles -> 64 grants to req1, 1 to req0, then req1 again.
REQ-041 SHALL cover: 3 issues, flush 2 cycles after the last issue -> no rspN_valid; busy=0 and alu_clk_en=0 the next cycle (no valids).
REQ-042 SHALL cover: rst_n low for 1 cycle with 3 operations in flight -> all outputs 0; no responses after release; the first contention is won by req0.
REQ-043 SHALL cover: flush and req0_valid in the same cycle -> req0_ready=0; req0 accepted the following cycle.

Source files
------------

// File: rtl/fpalu_pkg.sv
// Shared FPALU definitions: opcodes, floating-point field widths and the
// small types used by the arbiter and its tag pipeline.
package fpalu_pkg;

    // Opcodes presented to the FPALU.
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // FP29i operand format.
    localparam int FP29_S = 1;
    localparam int FP29_E = 6;
    localparam int FP29_M = 22;
    localparam int FP29_W = FP29_S + FP29_E + FP29_M;

    // FP16 format.
    localparam int FP16_S = 1;
    localparam int FP16_E = 5;
    localparam int FP16_M = 10;
    localparam int FP16_W = FP16_S + FP16_E + FP16_M;

    typedef logic [FP29_W-1:0] fp29_t;

    // One entry of the in-flight tag pipeline.
    typedef struct packed {
        logic valid;
        logic id;       // requester that issued the operation
    } tag_t;

    // Arbiter grant mode.
    typedef enum logic [1:0] {
        ARB_RR    = 2'b00,
        ARB_LOCK0 = 2'b01,
        ARB_LOCK1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/fpalu_arb_if.sv
// Bus between the two requesters, the FPALU and the arbiter.
interface fpalu_arb_if;
    import fpalu_pkg::*;

    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [1:0] req0_op;
    logic [1:0] req1_op;
    fp29_t      req0_a;
    fp29_t      req0_b;
    fp29_t      req1_a;
    fp29_t      req1_b;
    logic       req0_lock;
    logic       req1_lock;
    logic       flush;
    logic [1:0] alu_op;
    fp29_t      alu_a;
    fp29_t      alu_b;
    fp29_t      alu_y;
    logic       alu_clk_en;
    logic       rsp0_valid;
    logic       rsp1_valid;
    fp29_t      rsp_y;
    logic       busy;

    // Environment side: requesters plus the FPALU datapath.
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
               req0_a, req0_b, req1_a, req1_b,
               req0_lock, req1_lock, flush, alu_y,
        input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
               alu_clk_en, rsp0_valid, rsp1_valid, rsp_y, busy
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
               req0_a, req0_b, req1_a, req1_b,
               req0_lock, req1_lock, flush, alu_y,
        output req0_ready, req1_ready, alu_op, alu_a, alu_b,
               alu_clk_en, rsp0_valid, rsp1_valid, rsp_y, busy
    );

endinterface

// File: rtl/fpalu_arb_rr.sv
// Two-way round-robin arbiter with grant locking and forced release
// after LOCK_MAX consecutive locked grants.
module fpalu_arb_rr
    import fpalu_pkg::*;
#(
    parameter int LOCK_MAX = 64
) (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic lock0,
    input  logic lock1,
    input  logic flush,
    output logic ready0,
    output logic ready1
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t       state, state_nxt;
    logic             ptr, ptr_nxt;      // last granted requester
    logic [CNT_W-1:0] cnt, cnt_nxt;      // consecutive locked grants
    logic             g0, g1, rdy0, rdy1, lk, cont;
    logic [CNT_W-1:0] cnt_inc;

    // Grant mode, last-grant pointer and lock counter registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_RR;
            ptr   <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant selection and next-state for lock tracking.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        g0        = 1'b0;
        g1        = 1'b0;
        lk        = 1'b0;
        cont      = 1'b0;
        cnt_inc   = '0;

        unique case (state)
            ARB_LOCK0: begin
                g0 = valid0;
                g1 = !valid0 && valid1;
            end
            ARB_LOCK1: begin
                g1 = valid1;
                g0 = !valid1 && valid0;
            end
            default: begin
                if (valid0 && valid1) begin
                    g0 = ptr;
                    g1 = !ptr;
                end else begin
                    g0 = valid0;
                    g1 = valid1;
                end
            end
        endcase

        rdy0 = g0 && !flush && rst_n;
        rdy1 = g1 && !flush && rst_n;

        if (flush) begin
            state_nxt = ARB_RR;
            ptr_nxt   = 1'b1;
            cnt_nxt   = '0;
        end else if (rdy0 || rdy1) begin
            ptr_nxt = rdy1;
            lk      = rdy0 ? lock0 : lock1;
            cont    = (state == ARB_LOCK0 && rdy0) || (state == ARB_LOCK1 && rdy1);
            if (lk) begin
                cnt_inc = cont ? cnt + CNT_W'(1) : CNT_W'(1);
                if (cnt_inc == CNT_W'(LOCK_MAX)) begin
                    // Forced release: one round-robin cycle favours the other side.
                    state_nxt = ARB_RR;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = rdy0 ? ARB_LOCK0 : ARB_LOCK1;
                    cnt_nxt   = cnt_inc;
                end
            end else begin
                state_nxt = ARB_RR;
                cnt_nxt   = '0;
            end
        end else begin
            // No handshake: any lock lapses.
            state_nxt = ARB_RR;
            cnt_nxt   = '0;
        end
    end

    assign ready0 = rdy0;
    assign ready1 = rdy1;

endmodule

// File: rtl/fpalu_arb.sv
// FPALU front end: arbitrates two requesters onto one pipelined FPALU,
// registers the issued operation and routes each result back by tag.
module fpalu_arb
    import fpalu_pkg::*;
#(
    parameter int ALU_LAT  = 4,
    parameter int LOCK_MAX = 64
) (
    input  logic        clk_fast,
    input  logic        rst_n,
    fpalu_arb_if.slave  bus
);

    logic ready0, ready1, hs0, hs1, any_tag;
    tag_t pipe [ALU_LAT+1];

    fpalu_arb_rr #(.LOCK_MAX(LOCK_MAX)) u_rr (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .valid0   (bus.req0_valid),
        .valid1   (bus.req1_valid),
        .lock0    (bus.req0_lock),
        .lock1    (bus.req1_lock),
        .flush    (bus.flush),
        .ready0   (ready0),
        .ready1   (ready1)
    );

    assign hs0 = bus.req0_valid && ready0;
    assign hs1 = bus.req1_valid && ready1;

    // Operand registers: load on handshake, otherwise issue a NOP and hold operands.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_op <= OP_NOP;
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
        end else if (hs0) begin
            bus.alu_op <= bus.req0_op;
            bus.alu_a  <= bus.req0_a;
            bus.alu_b  <= bus.req0_b;
        end else if (hs1) begin
            bus.alu_op <= bus.req1_op;
            bus.alu_a  <= bus.req1_a;
            bus.alu_b  <= bus.req1_b;
        end else begin
            bus.alu_op <= OP_NOP;
        end
    end

    // Tag pipeline tracking which requester owns each in-flight result.
    // NOTE: this shift register is reset (unlike a data RAM) because stale valids would emit phantom responses.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ALU_LAT; i++) pipe[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i <= ALU_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: hs0 || hs1, id: hs1};
            for (int i = 1; i <= ALU_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Any operation still travelling through the FPALU.
    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i <= ALU_LAT; i++) any_tag = any_tag | pipe[i].valid;
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = pipe[ALU_LAT].valid && !pipe[ALU_LAT].id && !bus.flush;
    assign bus.rsp1_valid = pipe[ALU_LAT].valid &&  pipe[ALU_LAT].id && !bus.flush;
    assign bus.rsp_y      = bus.alu_y;
    assign bus.busy       = any_tag || (bus.alu_op != OP_NOP);
    assign bus.alu_clk_en = rst_n && (bus.req0_valid || bus.req1_valid || bus.busy);

endmodule

// File: tb/tb_fpalu_arb.sv
// Directed scoreboard bench for fpalu_arb: stimulus pushes expected
// responses, an independent monitor pops and compares them.
module tb_fpalu_arb;
    import fpalu_pkg::*;

    localparam int ALU_LAT  = 4;
    localparam int LOCK_MAX = 64;

    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_err    = 0;

    typedef struct {
        bit id;
        int cyc;
    } exp_t;
    exp_t sb[$];

    fpalu_arb_if bus ();

    fpalu_arb #(.ALU_LAT(ALU_LAT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk_fast = ~clk_fast;
    always @(posedge clk_fast) cyc <= cyc + 1;

    // FPALU stand-in: output is a known function of the cycle number.
    function automatic fp29_t y_of(input int c);
        return fp29_t'((c * 32'h00BEEF1) ^ 32'h0A5A5A5);
    endfunction

    assign bus.alu_y = y_of(cyc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the head of the scoreboard.
    always @(negedge clk_fast) begin
        exp_t e;
        if (rst_n && (bus.rsp0_valid || bus.rsp1_valid)) begin
            check("rsp_exclusive", 32'(bus.rsp0_valid && bus.rsp1_valid), 0);
            check("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_id", 32'(bus.rsp1_valid), 32'(e.id));
                check("rsp_cycle", cyc, e.cyc);
                check("rsp_y", bus.rsp_y, y_of(e.cyc));
            end
        end
    end

    // One cycle of stimulus; checks readies mid-cycle and records expected responses.
    task automatic step(input bit v0, input bit v1, input bit l0, input bit l1, input bit fl,
                        input bit e0, input bit e1, input string tag);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_lock  = l0;
        bus.req1_lock  = l1;
        bus.flush      = fl;
        @(negedge clk_fast);
        check({tag, "_ready0"}, bus.req0_ready, e0);
        check({tag, "_ready1"}, bus.req1_ready, e1);
        if (fl) sb.delete();
        if (e0) sb.push_back('{id: 1'b0, cyc: cyc + ALU_LAT + 1});
        if (e1) sb.push_back('{id: 1'b1, cyc: cyc + ALU_LAT + 1});
        @(posedge clk_fast);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    // Wait (bounded) for outstanding responses, then require an empty scoreboard.
    task automatic drain(input string tag);
        for (int i = 0; i < 12 && sb.size() != 0; i++) idle(1);
        idle(2);
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    // One-cycle reset with both requesters valid; all outputs must be forced low.
    task automatic do_reset(input string tag);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.flush      = 1'b0;
        rst_n          = 1'b0;
        sb.delete();
        @(negedge clk_fast);
        check({tag, "_ready0"}, bus.req0_ready, 0);
        check({tag, "_ready1"}, bus.req1_ready, 0);
        check({tag, "_alu_op"}, bus.alu_op, 0);
        check({tag, "_alu_a"}, bus.alu_a, 0);
        check({tag, "_alu_b"}, bus.alu_b, 0);
        check({tag, "_rsp0"}, bus.rsp0_valid, 0);
        check({tag, "_rsp1"}, bus.rsp1_valid, 0);
        check({tag, "_clk_en"}, bus.alu_clk_en, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_rsp_y"}, bus.rsp_y, y_of(cyc));
        @(posedge clk_fast);
        #1;
        rst_n          = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_lock  = 1'b0;
        bus.req1_lock  = 1'b0;
        bus.flush      = 1'b0;
        bus.req0_op    = OP_MUL;
        bus.req1_op    = OP_ADD;
        bus.req0_a     = 29'h0F000000;
        bus.req0_b     = 29'h0F000000;
        bus.req1_a     = 29'h01234567;
        bus.req1_b     = 29'h00ABCDEF;
        @(posedge clk_fast);
        #1;
        do_reset("reset");

        // Single MUL from req0.
        step(1, 0, 0, 0, 0, 1, 0, "t1_issue");
        check("t1_alu_op", bus.alu_op, OP_MUL);
        check("t1_alu_a", bus.alu_a, 29'h0F000000);
        check("t1_alu_b", bus.alu_b, 29'h0F000000);
        check("t1_busy", bus.busy, 1);
        step(0, 0, 0, 0, 0, 0, 0, "t1_gap");
        check("t1_nop", bus.alu_op, OP_NOP);
        check("t1_hold_a", bus.alu_a, 29'h0F000000);
        drain("t1");

        // Both valid after reset: strict alternation starting with req0.
        do_reset("t2_reset");
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 0, (i % 2) == 0, (i % 2) == 1, "t2_rr");
            if (i == 1) check("t2_alu_op_add", bus.alu_op, OP_ADD);
            if (i == 1) check("t2_alu_a_req1", bus.alu_a, 29'h01234567);
        end
        drain("t2");

        // req1 locks: 64 grants to req1, forced release to req0, then req1 again.
        step(0, 1, 0, 1, 0, 0, 1, "t3_lock_start");
        for (int i = 1; i < 70; i++) step(1, 1, 0, 1, 0, i == 64, i != 64, "t3_lock");
        bus.req1_lock = 1'b0;
        drain("t3");

        // Three issues, flush two cycles after the last: nothing comes back.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0, "t4_issue");
        step(0, 0, 0, 0, 0, 0, 0, "t4_wait");
        check("t4_busy_before", bus.busy, 1);
        step(0, 0, 0, 0, 1, 0, 0, "t4_flush");
        check("t4_busy_after", bus.busy, 0);
        check("t4_clk_en_after", bus.alu_clk_en, 0);
        idle(8);
        drain("t4");

        // Reset with work in flight; first contention afterwards goes to req0.
        step(1, 0, 0, 0, 0, 1, 0, "t5_issue");
        step(0, 1, 0, 0, 0, 0, 1, "t5_issue");
        step(1, 0, 0, 0, 0, 1, 0, "t5_issue");
        do_reset("t5_reset");
        step(1, 1, 0, 0, 0, 1, 0, "t5_first");
        idle(8);
        drain("t5");

        // Flush coincides with a request: refused that cycle, accepted next.
        step(1, 0, 0, 0, 1, 0, 0, "t6_flush");
        step(1, 0, 0, 0, 0, 1, 0, "t6_accept");
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
